// File: rtl/mouse_master_sm_pkg.sv
// Shared state codes and PS/2 command/response bytes for the
// mouse master sequencer.
package mouse_master_sm_pkg;

   typedef enum logic [3:0] {
      ST_INIT_WAIT     = 4'd0,
      ST_SEND_FF       = 4'd1,
      ST_WAIT_SENT_FF  = 4'd2,
      ST_WAIT_ACK_FF   = 4'd3,
      ST_WAIT_SELFTEST = 4'd4,
      ST_WAIT_ID       = 4'd5,
      ST_SEND_F4       = 4'd6,
      ST_WAIT_SENT_F4  = 4'd7,
      ST_WAIT_ACK_F4   = 4'd8,
      ST_READ_STATUS   = 4'd9,
      ST_READ_DX       = 4'd10,
      ST_READ_DY       = 4'd11,
      ST_PUBLISH       = 4'd12,
      ST_INIT_RESTART  = 4'd13
   } state_t;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_SELFTEST = 8'hAA;
   localparam logic [7:0] RSP_ID       = 8'h00;

   function automatic logic rx_state(state_t s);
      return s inside {ST_WAIT_ACK_FF, ST_WAIT_SELFTEST,
                       ST_WAIT_ID, ST_WAIT_ACK_F4,
                       ST_READ_STATUS, ST_READ_DX,
                       ST_READ_DY, ST_PUBLISH};
   endfunction

   function automatic logic pkt_state(state_t s);
      return s inside {ST_READ_STATUS, ST_READ_DX,
                       ST_READ_DY, ST_PUBLISH};
   endfunction

endpackage

// File: rtl/mouse_master_sm.sv
// PS/2 mouse master: runs the init handshake, then assembles
// 3-byte movement packets and publishes them with an interrupt.
module mouse_master_sm
   import mouse_master_sm_pkg::*;
#(
   parameter int STARTUP_CYCLES = 5000000,
   parameter int RESP_TIMEOUT   = 10000000,
   parameter int CNT_W          = 24
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic       BYTE_READY,
   input  logic [7:0] BYTE_IN,
   input  logic [1:0] BYTE_ERROR_CODE,
   output logic [7:0] MOUSE_STATUS,
   output logic [7:0] MOUSE_DX,
   output logic [7:0] MOUSE_DY,
   output logic       SEND_INTERRUPT,
   output logic [3:0] MASTER_STATE
);

   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(STARTUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(RESP_TIMEOUT - 1);

   state_t           state, nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [7:0]       status_r, dx_r;
   logic             rx_ok, tmo;

   assign rx_ok        = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
   assign tmo          = (cnt == TMO_LAST);
   assign MASTER_STATE = state;

   always_comb begin
      nxt = state;
      unique case (state)
         ST_INIT_WAIT:
            if (cnt == START_LAST) nxt = ST_SEND_FF;
         ST_SEND_FF:
            nxt = ST_WAIT_SENT_FF;
         ST_WAIT_SENT_FF:
            if (BYTE_SENT) nxt = ST_WAIT_ACK_FF;
            else if (tmo)  nxt = ST_INIT_RESTART;
         ST_WAIT_ACK_FF:
            if (BYTE_READY)
               nxt = (rx_ok && BYTE_IN == RSP_ACK) ?
                     ST_WAIT_SELFTEST : ST_INIT_RESTART;
            else if (tmo) nxt = ST_INIT_RESTART;
         ST_WAIT_SELFTEST:
            if (BYTE_READY)
               nxt = (rx_ok && BYTE_IN == RSP_SELFTEST) ?
                     ST_WAIT_ID : ST_INIT_RESTART;
            else if (tmo) nxt = ST_INIT_RESTART;
         ST_WAIT_ID:
            if (BYTE_READY)
               nxt = (rx_ok && BYTE_IN == RSP_ID) ?
                     ST_SEND_F4 : ST_INIT_RESTART;
            else if (tmo) nxt = ST_INIT_RESTART;
         ST_SEND_F4:
            nxt = ST_WAIT_SENT_F4;
         ST_WAIT_SENT_F4:
            if (BYTE_SENT) nxt = ST_WAIT_ACK_F4;
            else if (tmo)  nxt = ST_INIT_RESTART;
         ST_WAIT_ACK_F4:
            if (BYTE_READY)
               nxt = (rx_ok && BYTE_IN == RSP_ACK) ?
                     ST_READ_STATUS : ST_INIT_RESTART;
            else if (tmo) nxt = ST_INIT_RESTART;
         // bit 3 of a status byte is always set; anything else is desync
         ST_READ_STATUS:
            if (rx_ok && BYTE_IN[3]) nxt = ST_READ_DX;
         ST_READ_DX:
            if (BYTE_READY)
               nxt = rx_ok ? ST_READ_DY : ST_READ_STATUS;
         ST_READ_DY:
            if (BYTE_READY)
               nxt = rx_ok ? ST_PUBLISH : ST_READ_STATUS;
         ST_PUBLISH:
            nxt = ST_READ_STATUS;
         ST_INIT_RESTART:
            nxt = ST_SEND_FF;
         default:
            nxt = ST_INIT_WAIT;
      endcase
   end

   always_comb begin
      cnt_nxt = cnt + 1'b1;
      if (nxt != state || pkt_state(state))
         cnt_nxt = '0;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state          <= ST_INIT_WAIT;
         cnt            <= '0;
         SEND_BYTE      <= 1'b0;
         BYTE_TO_SEND   <= 8'h00;
         READ_ENABLE    <= 1'b0;
         SEND_INTERRUPT <= 1'b0;
         MOUSE_STATUS   <= 8'h00;
         MOUSE_DX       <= 8'h00;
         MOUSE_DY       <= 8'h00;
         status_r       <= 8'h00;
         dx_r           <= 8'h00;
      end else begin
         state          <= nxt;
         cnt            <= cnt_nxt;
         SEND_BYTE      <= (nxt == ST_SEND_FF) || (nxt == ST_SEND_F4);
         READ_ENABLE    <= rx_state(nxt);
         SEND_INTERRUPT <= (nxt == ST_PUBLISH);
         if (nxt == ST_SEND_FF)
            BYTE_TO_SEND <= CMD_RESET;
         else if (nxt == ST_SEND_F4)
            BYTE_TO_SEND <= CMD_ENABLE;
         if (state == ST_READ_STATUS && nxt == ST_READ_DX)
            status_r <= BYTE_IN;
         if (state == ST_READ_DX && nxt == ST_READ_DY)
            dx_r <= BYTE_IN;
         // dY is still on BYTE_IN, so all three land together
         if (nxt == ST_PUBLISH) begin
            MOUSE_STATUS <= status_r;
            MOUSE_DX     <= dx_r;
            MOUSE_DY     <= BYTE_IN;
         end
      end
   end

endmodule
